// File: rtl/spi_slave.sv
// Mode-0 SPI slave, oversampled in the clk_i domain: synchronized SCLK/CS_N/MOSI,
// one-byte TX holding register, level-valid RX byte with overrun/underrun pulses.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_load_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ack_i,
    output logic       rx_overrun_o,
    output logic       tx_underrun_o,
    output logic [9:0] n_rx_o,
    output logic       busy_o
);

    typedef enum logic {StIdle, StShift} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_prev_q, cs_prev_q, mosi_prev_q;
    logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       underrun_q, underrun_d;
    logic [9:0] n_rx_q, n_rx_d;
    logic       need_load;
    logic [7:0] load_byte;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        sclk_rise_d = sclk_s & ~sclk_prev_q;
        sclk_fall_d = ~sclk_s & sclk_prev_q;
        cs_rise_d   = cs_s & ~cs_prev_q;
        cs_fall_d   = ~cs_s & cs_prev_q;
    end

    // A byte-boundary reload is skipped when the selection is ending anyway.
    assign need_load = ((state_q == StIdle) && cs_fall_q) ||
                       ((state_q == StShift) && sclk_fall_q && (bit_cnt_q == 3'd0) && !cs_rise_q);

    always_comb begin
        load_byte = 8'h00;
        if (hold_full_q) begin
            load_byte = hold_q;
        end else if (tx_load_i) begin
            load_byte = tx_data_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        underrun_d  = need_load & ~hold_full_q & ~tx_load_i;
        n_rx_d      = n_rx_q;

        if (rx_ack_i) begin
            rx_valid_d = 1'b0;
        end
        if (need_load) begin
            hold_full_d = 1'b0;
        end else if (tx_load_i && !hold_full_q) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (cs_fall_q) begin
                    state_d    = StShift;
                    bit_cnt_d  = 3'd0;
                    tx_shift_d = load_byte;
                    miso_d     = load_byte[7];
                    oe_d       = 1'b1;
                end
            end
            StShift: begin
                if (sclk_rise_q) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_prev_q};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_shift_q[6:0], mosi_prev_q};
                        rx_valid_d = 1'b1;
                        overrun_d  = rx_valid_q & ~rx_ack_i;
                        n_rx_d     = n_rx_q + 10'd1;
                    end
                end else if (sclk_fall_q) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end else if (need_load) begin
                        tx_shift_d = load_byte;
                        miso_d     = load_byte[7];
                    end
                end
                if (cs_rise_q) begin
                    state_d    = StIdle;
                    bit_cnt_d  = 3'd0;
                    oe_d       = 1'b0;
                    miso_d     = 1'b0;
                    rx_shift_d = 8'h00;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            mosi_prev_q <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            n_rx_q      <= 10'd0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            mosi_prev_q <= mosi_s;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            n_rx_q      <= n_rx_d;
        end
    end

    assign miso_o        = miso_q;
    assign miso_oe_o     = oe_q;
    assign tx_ready_o    = ~hold_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_overrun_o  = overrun_q;
    assign tx_underrun_o = underrun_q;
    assign n_rx_o        = n_rx_q;
    assign busy_o        = (state_q == StShift);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-byte frames plus hand-written
// sequences for multi-byte overrun, aborted frames, counter wrap and mid-frame reset.
module tb_spi_slave;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       sclk_i = 1'b0;
    logic       cs_n_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic       miso_o, miso_oe_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_load_i = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ack_i = 1'b0;
    logic       rx_overrun_o, tx_underrun_o;
    logic [9:0] n_rx_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int under_cnt = 0;
    int over_cnt = 0;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .sclk_i       (sclk_i),
        .cs_n_i       (cs_n_i),
        .mosi_i       (mosi_i),
        .miso_o       (miso_o),
        .miso_oe_o    (miso_oe_o),
        .tx_data_i    (tx_data_i),
        .tx_load_i    (tx_load_i),
        .tx_ready_o   (tx_ready_o),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ack_i     (rx_ack_i),
        .rx_overrun_o (rx_overrun_o),
        .tx_underrun_o(tx_underrun_o),
        .n_rx_o       (n_rx_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (tx_underrun_o) under_cnt++;
        if (rx_overrun_o) over_cnt++;
    end

    typedef struct {
        logic       do_load;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        int         exp_under;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data_i = v;
        tx_load_i = 1'b1;
        tick(1);
        tx_load_i = 1'b0;
    endtask

    task automatic ack_rx();
        rx_ack_i = 1'b1;
        tick(1);
        rx_ack_i = 1'b0;
        tick(1);
    endtask

    // Mode 0: MOSI set and MISO sampled while SCLK low; with last=1 CS_N rises
    // after the final rising edge so the frame ends without a byte-boundary reload.
    task automatic xfer(input logic [7:0] d, input int nbits, input int h, input bit last,
                        output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_i = d[7-i];
            tick(h);
            m[7-i] = miso_o;
            sclk_i = 1'b1;
            tick(h);
            if (last && (i == nbits - 1)) begin
                cs_n_i = 1'b1;
                tick(h);
            end
            sclk_i = 1'b0;
        end
    endtask

    vec_t       vecs[4];
    logic [7:0] m, m2;
    int         n_model = 0;
    int         u0, o0;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 1};
        vecs[2] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 0};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1};

        tick(3);
        rst_n_i = 1'b1;
        tick(1);
        check("reset_miso", miso_o, 0);
        check("reset_oe", miso_oe_o, 0);
        check("reset_ready", tx_ready_o, 1);
        check("reset_rx_data", rx_data_o, 0);
        check("reset_rx_valid", rx_valid_o, 0);
        check("reset_n_rx", n_rx_o, 0);
        check("reset_busy", busy_o, 0);

        for (int v = 0; v < 4; v++) begin
            ack_rx();
            u0 = under_cnt;
            if (vecs[v].do_load) begin
                load_tx(vecs[v].tx);
                check("load_ready_low", tx_ready_o, 0);
            end
            cs_n_i = 1'b0;
            tick(8);
            check("frame_busy", busy_o, 1);
            check("frame_oe", miso_oe_o, 1);
            xfer(vecs[v].mosi, 8, 8, 1'b1, m);
            tick(8);
            n_model++;
            check("frame_miso", m, vecs[v].exp_miso);
            check("frame_rx_data", rx_data_o, vecs[v].mosi);
            check("frame_rx_valid", rx_valid_o, 1);
            check("frame_n_rx", n_rx_o, n_model);
            check("frame_ready", tx_ready_o, 1);
            check("frame_oe_off", miso_oe_o, 0);
            check("frame_underruns", under_cnt - u0, vecs[v].exp_under);
        end

        // Two bytes in one selection without acknowledging the first.
        ack_rx();
        check("ack_clears_valid", rx_valid_o, 0);
        o0 = over_cnt;
        cs_n_i = 1'b0;
        tick(8);
        xfer(8'h11, 8, 8, 1'b0, m);
        xfer(8'h22, 8, 8, 1'b1, m2);
        tick(8);
        n_model += 2;
        check("two_overrun", over_cnt - o0, 1);
        check("two_rx_data", rx_data_o, 8'h22);
        check("two_n_rx", n_rx_o, n_model);

        // Aborted frame after five bits, then a clean frame.
        ack_rx();
        cs_n_i = 1'b0;
        tick(8);
        xfer(8'hF0, 5, 8, 1'b1, m);
        tick(8);
        check("abort_valid", rx_valid_o, 0);
        check("abort_n_rx", n_rx_o, n_model);
        check("abort_oe", miso_oe_o, 0);
        check("abort_busy", busy_o, 0);
        load_tx(8'h96);
        cs_n_i = 1'b0;
        tick(8);
        xfer(8'h81, 8, 8, 1'b1, m);
        tick(8);
        n_model++;
        check("after_abort_rx", rx_data_o, 8'h81);
        check("after_abort_miso", m, 8'h96);
        check("after_abort_n_rx", n_rx_o, n_model);

        // Run the counter up to 1023 at the fastest legal SCLK, then wrap.
        rx_ack_i = 1'b1;
        cs_n_i = 1'b0;
        tick(4);
        while (n_model < 1023) begin
            xfer(n_model[7:0], 8, 4, 1'b0, m);
            n_model++;
        end
        tick(8);
        check("count_1023", n_rx_o, 10'd1023);
        xfer(8'h5A, 8, 4, 1'b1, m);
        tick(8);
        check("count_wrap", n_rx_o, 10'd0);
        rx_ack_i = 1'b0;
        tick(2);

        // Reset in the middle of a byte, with state present to clear.
        load_tx(8'h77);
        cs_n_i = 1'b0;
        tick(8);
        xfer(8'h96, 8, 8, 1'b0, m);
        xfer(8'hE0, 3, 8, 1'b0, m);
        sclk_i = 1'b1;
        tick(8);
        check("pre_reset_valid", rx_valid_o, 1);
        rst_n_i = 1'b0;
        tick(2);
        check("rst_miso", miso_o, 0);
        check("rst_oe", miso_oe_o, 0);
        check("rst_ready", tx_ready_o, 1);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_overrun", rx_overrun_o, 0);
        check("rst_underrun", tx_underrun_o, 0);
        check("rst_n_rx", n_rx_o, 0);
        check("rst_busy", busy_o, 0);
        cs_n_i = 1'b1;
        sclk_i = 1'b0;
        tick(2);
        rst_n_i = 1'b1;
        tick(8);
        check("post_rst_busy", busy_o, 0);
        load_tx(8'h3C);
        cs_n_i = 1'b0;
        tick(8);
        xfer(8'h69, 8, 8, 1'b1, m);
        tick(8);
        check("post_rst_rx", rx_data_o, 8'h69);
        check("post_rst_miso", m, 8'h3C);
        check("post_rst_n_rx", n_rx_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
